// File: rtl/instr_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder: word size, NOP encoding,
// FSM state encoding and the fetch address check.
package instr_fetch_responder_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } fetch_state_t;

  // The word offset is only meaningful once addr >= base, so the base test guards it;
  // this keeps addresses that wrap past 2^32 out of range instead of aliasing them.
  function automatic logic fetchErr(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input logic [XLEN-1:0] depth);
    logic [XLEN-1:0] wordOff;
    wordOff = (addr - base) >> 2;
    return (addr < base) || (wordOff >= depth) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_responder_imem_rom.sv
// Synchronous-read single-port instruction ROM; contents are provided by the environment.
// Neither the array nor the read register is reset.
module imem_rom #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  output logic [31:0]                    rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) rdata <= r_mem[addr];
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Memory-side responder for the CPU fetch port: one request in flight, fixed latency,
// address range/alignment checking and flush on taken branches.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  output logic [31:0] rsp_addr,
  input  logic        flush
);

  localparam int AW = $clog2(DEPTH_WORDS);

  fetch_state_t          r_state;
  fetch_state_t          w_next;
  logic [WAIT_CNT_W-1:0] r_waitCnt;
  logic [XLEN-1:0]       r_addr;
  logic                  r_err;
  logic [XLEN-1:0]       r_rspInstr;
  logic [XLEN-1:0]       r_rspAddr;
  logic                  r_rspErr;

  logic                  w_reqReady;
  logic                  w_accept;
  logic                  w_loadRsp;
  logic                  w_reqErr;
  logic                  w_romEn;
  logic [AW-1:0]         w_romAddr;
  logic [XLEN-1:0]       w_romData;

  assign w_reqErr  = fetchErr(req_addr, BASE_ADDR, XLEN'(DEPTH_WORDS));
  assign w_romAddr = AW'((req_addr - BASE_ADDR) >> 2);
  assign w_accept  = w_reqReady && req_valid;

  // The ROM is read on the accepting edge and its output is left untouched until the
  // next accept, so it is still valid when the response registers capture it.
  assign w_romEn   = w_accept && !w_reqErr;

  imem_rom #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_rom (
    .clk   (clk),
    .en    (w_romEn),
    .addr  (w_romAddr),
    .rdata (w_romData)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_reqReady = 1'b0;
    case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
        if (req_valid) w_next = READ;
      end
      READ: begin
        w_next = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (r_waitCnt == WAIT_CNT_W'(WAIT_STATES - 1)) w_next = RESP;
      end
      RESP: begin
        w_reqReady = rsp_ready;
        if (rsp_ready) w_next = req_valid ? READ : IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Flush beats everything, including a handshake that would otherwise complete.
    if (flush) begin
      w_next     = IDLE;
      w_reqReady = 1'b0;
    end
  end

  assign w_loadRsp = (r_state != RESP) && (w_next == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_waitCnt <= '0;
    else if (r_state == WAIT && w_next == WAIT) r_waitCnt <= r_waitCnt + 1'b1;
    else                                       r_waitCnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_rspInstr <= '0;
      r_rspAddr  <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
        r_err  <= w_reqErr;
      end
      if (w_loadRsp) begin
        r_rspInstr <= r_err ? NOP_INSTR : w_romData;
        r_rspAddr  <= r_addr;
        r_rspErr   <= r_err;
      end
    end
  end

  assign req_ready = w_reqReady;
  assign rsp_valid = (r_state == RESP);
  assign rsp_instr = r_rspInstr;
  assign rsp_err   = r_rspErr;
  assign rsp_addr  = r_rspAddr;

endmodule
